// File: rtl/wb_stage_buf.sv
// Writeback stage with a DEPTH-entry pending-write FIFO toward register_file.
// Also provides a hazard lookup over pending writes. Optional same-cycle bypass: WB_STAGE_BUF_BYPASS_EN.
module wb_stage_buf #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int NUM_SRC    = 2,
   parameter int SEL_W      = 1,
   parameter int DEPTH      = 4
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [NUM_SRC*DATA_W+REG_ADDR_W+SEL_W:0]     pipeline_reg_in,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   output logic                                         reg_write_en,
   output logic [REG_ADDR_W-1:0]                        reg_write_dest,
   output logic [DATA_W-1:0]                            reg_write_data,
   input  logic                                         reg_write_ready,
   output logic [REG_ADDR_W-1:0]                        wb_op_dest,
   input  logic [REG_ADDR_W-1:0]                        hz_addr,
   output logic                                         hz_hit,
   output logic [DATA_W-1:0]                            hz_data,
   output logic [$clog2(DEPTH):0]                       pending_cnt
);

   localparam int IN_W  = NUM_SRC*DATA_W + 1 + REG_ADDR_W + SEL_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                  inEn;
   logic [REG_ADDR_W-1:0] inDest;
   logic [SEL_W-1:0]      inSel;
   logic [DATA_W-1:0]     inData;

   logic [REG_ADDR_W-1:0] destMem_q [DEPTH];
   logic [DATA_W-1:0]     dataMem_q [DEPTH];
   logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic fifoEmpty;
   logic bypassAct;
   logic push;
   logic pop;

   assign inSel  = pipeline_reg_in[SEL_W-1:0];
   assign inDest = pipeline_reg_in[SEL_W +: REG_ADDR_W];
   assign inEn   = pipeline_reg_in[SEL_W+REG_ADDR_W];

   // src0 occupies the most significant field; out-of-range selects yield zero.
   always_comb begin
      inData = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (inSel == SEL_W'(k)) begin
            inData = pipeline_reg_in[IN_W-1-k*DATA_W -: DATA_W];
         end
      end
   end

   assign fifoEmpty = (count_q == '0);
   assign in_ready  = (count_q != CNT_W'(DEPTH));

`ifdef WB_STAGE_BUF_BYPASS_EN
   assign bypassAct = fifoEmpty && in_valid && inEn;
`else
   assign bypassAct = 1'b0;
`endif

   // A bypassed write that the register file takes this cycle never enters the FIFO.
   assign push = in_valid && in_ready && inEn && !(bypassAct && reg_write_ready);
   assign pop  = !fifoEmpty && reg_write_ready;

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            destMem_q[i] <= '0;
            dataMem_q[i] <= '0;
         end
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
         if (push) begin
            destMem_q[wrPtr_q] <= inDest;
            dataMem_q[wrPtr_q] <= inData;
         end
      end
   end

   always_comb begin
      reg_write_en   = 1'b0;
      reg_write_dest = '0;
      reg_write_data = '0;
      wb_op_dest     = '0;
      if (!fifoEmpty) begin
         reg_write_en   = 1'b1;
         reg_write_dest = destMem_q[rdPtr_q];
         reg_write_data = dataMem_q[rdPtr_q];
         wb_op_dest     = destMem_q[rdPtr_q];
      end else if (bypassAct) begin
         reg_write_en   = 1'b1;
         reg_write_dest = inDest;
         reg_write_data = inData;
      end
   end

   // Scan oldest to youngest so the last match found is the most recent push.
   always_comb begin
      hz_hit  = 1'b0;
      hz_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) && (destMem_q[rdPtr_q + PTR_W'(i)] == hz_addr)) begin
            hz_hit  = 1'b1;
            hz_data = dataMem_q[rdPtr_q + PTR_W'(i)];
         end
      end
      if (bypassAct && (inDest == hz_addr)) begin
         hz_hit  = 1'b1;
         hz_data = inData;
      end
   end

   assign pending_cnt = count_q;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed self-checking bench for wb_stage_buf (default parameters).
// Exercises WB_STAGE_BUF_BYPASS_EN behaviour when that macro is defined.
module tb_wb_stage_buf;

   logic        clk;
   logic        rst_n;
   logic [36:0] pipeline_reg_in;
   logic        in_valid;
   logic        in_ready;
   logic        reg_write_en;
   logic [2:0]  reg_write_dest;
   logic [15:0] reg_write_data;
   logic        reg_write_ready;
   logic [2:0]  wb_op_dest;
   logic [2:0]  hz_addr;
   logic        hz_hit;
   logic [15:0] hz_data;
   logic [2:0]  pending_cnt;

   int checks = 0;
   int passes = 0;

   wb_stage_buf dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pipeline_reg_in (pipeline_reg_in),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .reg_write_en    (reg_write_en),
      .reg_write_dest  (reg_write_dest),
      .reg_write_data  (reg_write_data),
      .reg_write_ready (reg_write_ready),
      .wb_op_dest      (wb_op_dest),
      .hz_addr         (hz_addr),
      .hz_hit          (hz_hit),
      .hz_data         (hz_data),
      .pending_cnt     (pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [36:0] mkWord(input logic [15:0] s0, input logic [15:0] s1,
                                          input logic en, input logic [2:0] dest, input logic sel);
      return {s0, s1, en, dest, sel};
   endfunction

   // Inputs change 1 time unit after the rising edge, well clear of sampling.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      reg_write_ready = 1'b1;
      pipeline_reg_in = '0;
      hz_addr = 3'd0;
      #23;
      checks++; if (reg_write_en !== 1'b0) $display("[TB] FAIL reset_en: got %0b want 0", reg_write_en); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); else passes++;
      checks++; if (pending_cnt !== 3'd0) $display("[TB] FAIL reset_cnt: got %0d want 0", pending_cnt); else passes++;
      checks++; if ({reg_write_dest, reg_write_data, wb_op_dest} !== 22'd0)
         $display("[TB] FAIL reset_outs: got %h/%h/%h want 0", reg_write_dest, reg_write_data, wb_op_dest); else passes++;
      checks++; if ({hz_hit, hz_data} !== 17'd0) $display("[TB] FAIL reset_hz: got %0b/%h want 0/0", hz_hit, hz_data); else passes++;
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_basic();
      reg_write_ready = 1'b1;
      pipeline_reg_in = mkWord(16'hf421, 16'h69fe, 1'b1, 3'b010, 1'b1);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++; if (reg_write_en !== 1'b1) $display("[TB] FAIL basic_en: got %0b want 1", reg_write_en); else passes++;
      checks++; if (reg_write_dest !== 3'b010) $display("[TB] FAIL basic_dest: got %b want 010", reg_write_dest); else passes++;
      checks++; if (reg_write_data !== 16'h69fe) $display("[TB] FAIL basic_data: got %h want 69fe", reg_write_data); else passes++;
      checks++; if (wb_op_dest !== 3'b010) $display("[TB] FAIL basic_opdest: got %b want 010", wb_op_dest); else passes++;
      cycle();
      checks++; if (reg_write_en !== 1'b0) $display("[TB] FAIL basic_drain: got %0b want 0", reg_write_en); else passes++;
      checks++; if (wb_op_dest !== 3'b000) $display("[TB] FAIL basic_opdest_empty: got %b want 000", wb_op_dest); else passes++;

      pipeline_reg_in = mkWord(16'hf421, 16'h69fe, 1'b1, 3'b110, 1'b0);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++; if (reg_write_dest !== 3'b110) $display("[TB] FAIL sel0_dest: got %b want 110", reg_write_dest); else passes++;
      checks++; if (reg_write_data !== 16'hf421) $display("[TB] FAIL sel0_data: got %h want f421", reg_write_data); else passes++;
      cycle();

      pipeline_reg_in = mkWord(16'hf421, 16'h69fe, 1'b0, 3'b110, 1'b0);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++; if (pending_cnt !== 3'd0) $display("[TB] FAIL noen_cnt: got %0d want 0", pending_cnt); else passes++;
      checks++; if (reg_write_en !== 1'b0) $display("[TB] FAIL noen_en: got %0b want 0", reg_write_en); else passes++;
   endtask

   task automatic test_full();
      reg_write_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         pipeline_reg_in = mkWord(16'h1000 + 16'(i), 16'hdead, 1'b1, 3'(i), 1'b0);
         in_valid = 1'b1;
         cycle();
      end
      pipeline_reg_in = mkWord(16'h1005, 16'hdead, 1'b1, 3'd7, 1'b0);
      checks++; if (pending_cnt !== 3'd4) $display("[TB] FAIL full_cnt: got %0d want 4", pending_cnt); else passes++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL full_ready: got %0b want 0", in_ready); else passes++;
      cycle();
      in_valid = 1'b0;
      checks++; if (pending_cnt !== 3'd4) $display("[TB] FAIL full_reject: got %0d want 4", pending_cnt); else passes++;
      reg_write_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (reg_write_dest !== 3'(i) || reg_write_data !== 16'h1000 + 16'(i))
            $display("[TB] FAIL drain_order%0d: got %0d/%h want %0d/%h", i, reg_write_dest, reg_write_data, i, 16'h1000 + 16'(i));
         else passes++;
         cycle();
         if (i == 1) begin
            checks++; if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_pop: got %0b want 1", in_ready); else passes++;
         end
      end
      checks++; if (pending_cnt !== 3'd0 || reg_write_en !== 1'b0)
         $display("[TB] FAIL full_drained: got cnt %0d en %0b want 0/0", pending_cnt, reg_write_en); else passes++;
   endtask

   task automatic test_hazard();
      reg_write_ready = 1'b0;
      pipeline_reg_in = mkWord(16'h1111, 16'h0, 1'b1, 3'd5, 1'b0);
      in_valid = 1'b1;
      cycle();
      pipeline_reg_in = mkWord(16'h0, 16'h2222, 1'b1, 3'd5, 1'b1);
      cycle();
      in_valid = 1'b0;
      hz_addr = 3'd5;
      #1;
      checks++; if (hz_hit !== 1'b1 || hz_data !== 16'h2222)
         $display("[TB] FAIL hz_youngest: got %0b/%h want 1/2222", hz_hit, hz_data); else passes++;
      hz_addr = 3'd6;
      #1;
      checks++; if (hz_hit !== 1'b0 || hz_data !== 16'h0)
         $display("[TB] FAIL hz_miss: got %0b/%h want 0/0000", hz_hit, hz_data); else passes++;
      hz_addr = 3'd5;
      reg_write_ready = 1'b1;
      #1;
      checks++; if (reg_write_data !== 16'h1111) $display("[TB] FAIL hz_head: got %h want 1111", reg_write_data); else passes++;
      cycle();
      checks++; if (hz_hit !== 1'b1 || hz_data !== 16'h2222 || pending_cnt !== 3'd1)
         $display("[TB] FAIL hz_after_pop: got %0b/%h cnt %0d want 1/2222 cnt 1", hz_hit, hz_data, pending_cnt); else passes++;
      cycle();
      checks++; if (hz_hit !== 1'b0) $display("[TB] FAIL hz_empty: got %0b want 0", hz_hit); else passes++;
   endtask

   task automatic test_back_to_back();
      reg_write_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pipeline_reg_in = mkWord(16'h0, 16'h2000 + 16'(i), 1'b1, 3'(i), 1'b1);
         cycle();
         checks++; if (pending_cnt !== 3'd1 || reg_write_data !== 16'h2000 + 16'(i) || reg_write_dest !== 3'(i))
            $display("[TB] FAIL stream%0d: got cnt %0d %0d/%h want 1 %0d/%h", i, pending_cnt, reg_write_dest,
                     reg_write_data, i, 16'h2000 + 16'(i));
         else passes++;
      end
      in_valid = 1'b0;
      cycle();
      reg_write_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pipeline_reg_in = mkWord(16'h3000 + 16'(i), 16'h0, 1'b1, 3'd1, 1'b0);
         cycle();
      end
      in_valid = 1'b0;
      checks++; if (pending_cnt !== 3'd3) $display("[TB] FAIL pre_reset_cnt: got %0d want 3", pending_cnt); else passes++;
      rst_n = 1'b0;
      #1;
      checks++; if (reg_write_en !== 1'b0 || pending_cnt !== 3'd0 || in_ready !== 1'b1)
         $display("[TB] FAIL midreset: got en %0b cnt %0d rdy %0b want 0/0/1", reg_write_en, pending_cnt, in_ready); else passes++;
      #1;
      rst_n = 1'b1;
      reg_write_ready = 1'b1;
      cycle();
      cycle();
      checks++; if (reg_write_en !== 1'b0 || pending_cnt !== 3'd0)
         $display("[TB] FAIL post_reset: got en %0b cnt %0d want 0/0", reg_write_en, pending_cnt); else passes++;
   endtask

`ifdef WB_STAGE_BUF_BYPASS_EN
   task automatic test_bypass();
      reg_write_ready = 1'b1;
      hz_addr = 3'b101;
      pipeline_reg_in = mkWord(16'h0, 16'hbeef, 1'b1, 3'b101, 1'b1);
      in_valid = 1'b1;
      #1;
      checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'b101 || reg_write_data !== 16'hbeef)
         $display("[TB] FAIL bypass_out: got %0b %b/%h want 1 101/beef", reg_write_en, reg_write_dest, reg_write_data); else passes++;
      checks++; if (hz_hit !== 1'b1 || hz_data !== 16'hbeef)
         $display("[TB] FAIL bypass_hz: got %0b/%h want 1/beef", hz_hit, hz_data); else passes++;
      cycle();
      in_valid = 1'b0;
      checks++; if (pending_cnt !== 3'd0 || reg_write_en !== 1'b0)
         $display("[TB] FAIL bypass_nopush: got cnt %0d en %0b want 0/0", pending_cnt, reg_write_en); else passes++;
   endtask
`else
   task automatic test_no_bypass();
      reg_write_ready = 1'b1;
      hz_addr = 3'b101;
      pipeline_reg_in = mkWord(16'h0, 16'hbeef, 1'b1, 3'b101, 1'b1);
      in_valid = 1'b1;
      #1;
      checks++; if (reg_write_en !== 1'b0 || hz_hit !== 1'b0)
         $display("[TB] FAIL nobypass_same: got en %0b hit %0b want 0/0", reg_write_en, hz_hit); else passes++;
      cycle();
      in_valid = 1'b0;
      checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'b101 || reg_write_data !== 16'hbeef)
         $display("[TB] FAIL nobypass_next: got %0b %b/%h want 1 101/beef", reg_write_en, reg_write_dest, reg_write_data); else passes++;
      cycle();
      checks++; if (pending_cnt !== 3'd0) $display("[TB] FAIL nobypass_drain: got %0d want 0", pending_cnt); else passes++;
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_hazard();
      test_back_to_back();
`ifdef WB_STAGE_BUF_BYPASS_EN
      test_bypass();
`else
      test_no_bypass();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
- Parametrised successor to the single-cycle writeback stage.
- Selects the writeback result from NUM_SRC packed sources, then queues enabled writes in a DEPTH-entry FIFO that drains to the register-file write port under a ready handshake.
- Sits between the MEM/WB pipeline register and register_file.
- Also exposes a pending-write lookup (hit + youngest data) so the hazard/forwarding unit can bypass values not yet committed.

Parameters:
DATA_W, 16, register data width
REG_ADDR_W, 3, register index width
NUM_SRC, 2, number of result sources in the input word
SEL_W, 1, source-select width; must satisfy 2**SEL_W >= NUM_SRC
DEPTH, 4, pending-write FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pipeline_reg_in  input  NUM_SRC*DATA_W+1+REG_ADDR_W+SEL_W  MSB-first {src0, src1, ..., src[NUM_SRC-1], wb_en, wb_dest, wb_sel}
in_valid  input  1  pipeline_reg_in valid this cycle
in_ready  output  1  stage can accept (FIFO not full)
reg_write_en  output  1  head write valid toward register_file
reg_write_dest  output  REG_ADDR_W  head destination
reg_write_data  output  DATA_W  head data
reg_write_ready  input  1  register_file accepts head this cycle
wb_op_dest  output  REG_ADDR_W  head destination; 0 when empty
hz_addr  input  REG_ADDR_W  hazard lookup address
hz_hit  output  1  some pending entry targets hz_addr
hz_data  output  DATA_W  data of youngest matching entry; 0 if no hit
pending_cnt  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset: rd/wr pointers and count go to 0. All outputs are 0 except in_ready, which is 1. Asserting reset mid-operation discards every pending write; nothing is written after release until a new input arrives.
- Source select: wb_sel=k selects src k. If wb_sel >= NUM_SRC, data = 0.
  - With NUM_SRC=2: sel=0 selects the upper 16-bit field, sel=1 the lower.
- Accept: transfer occurs when in_valid && in_ready.
  - wb_en=1: {dest, selected data} is pushed at the wr pointer.
  - wb_en=0: the word is consumed and dropped; no push, count unchanged.
- in_ready = (pending_cnt != DEPTH). It is combinational and does not depend on the same-cycle pop.
- Pop: occurs when reg_write_en && reg_write_ready; the rd pointer advances.
- Output: reg_write_en = (pending_cnt != 0). reg_write_dest and reg_write_data come from the head entry. When empty, dest and data are 0.
- Latency: an entry accepted at edge N is visible on reg_write_* in the cycle after edge N (1 cycle).
- Simultaneous push and pop: both occur and count is unchanged. On an empty FIFO the new entry becomes head after the edge.
- Full: no push (in_ready=0). A pop in the same cycle does not allow a push that cycle.
- Pointers wrap modulo DEPTH.
- Ordering: writes to the same dest commit in arrival order.
- Hazard lookup is combinational over all valid entries.
  - hz_hit=1 if any entry's dest == hz_addr.
  - hz_data = data of the most recently pushed matching entry.
  - The head entry counts as pending, even while being popped in the current cycle.
- Dest 0 receives no special handling.

Optional Feature:
- Macro: WB_STAGE_BUF_BYPASS_EN.
- Defined: when the FIFO is empty and in_valid && wb_en:
  - reg_write_en/dest/data reflect the input combinationally in the same cycle.
  - If reg_write_ready is also 1, the write completes with no push (0 latency).
  - Otherwise the entry is pushed normally.
  - hz_hit/hz_data also match the bypassing input.
- Undefined: no combinational input-to-output path; latency is always 1 cycle.

Test Plan:
- Reset, then pipeline_reg_in={16'hf421,16'h69fe,5'b10101}, in_valid=1 for 1 cycle, reg_write_ready=1 -> next cycle reg_write_en=1, dest=3'b010, data=16'h69fe, wb_op_dest=3'b010; following cycle reg_write_en=0.
- Input {16'hf421,16'h69fe,5'b11100} -> dest=3'b110, data=16'hf421. Input {...,5'b01100} (wb_en=0) -> no write, pending_cnt stays 0.
- reg_write_ready=0, push 4 writes to dests 1,2,3,4 -> pending_cnt=4, in_ready=0; a 5th in_valid is not accepted. Raise ready -> writes commit in order 1,2,3,4 over 4 cycles; in_ready rises after the first pop edge.
- reg_write_ready=0, push dest 5 data 16'h1111 then dest 5 data 16'h2222; hz_addr=5 -> hz_hit=1, hz_data=16'h2222. hz_addr=6 -> hz_hit=0, hz_data=0.
- Continuous push and pop for 10 cycles with ready=1 -> pending_cnt constant at 1, pointers wrap, data sequence unbroken. Assert rst_n=0 mid-stream with 3 pending -> reg_write_en=0, pending_cnt=0 immediately.
- With WB_STAGE_BUF_BYPASS_EN defined, empty FIFO, ready=1, push {16'h0,16'hbeef,5'b11011} -> same cycle reg_write_en=1, dest=3'b101, data=16'hbeef; pending_cnt stays 0.
